reg_bank_ctrl: RTL

- Initiator-side controller for the register bank's read/write port.
- Serialises core writeback requests and operand-read requests onto the bank's single-cycle port: write_enable, address_a, address_b, write_address, write_data in; data_a, data_b out.
- Bank timing it targets: a write-enabled edge writes only; a non-write edge captures the read data.
- Sits between the REDUX-V decode/execute stages and the bank; owns the valid/ready handshakes and the read latency.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register-bank port controller: state encoding and
// default geometry.
package reg_bank_pkg;

  localparam int STATE_W      = 3;
  localparam int DEF_BITS     = 8;
  localparam int DEF_REG_BITS = 8;
  localparam int DEF_REG_SIZE = 2;

  localparam logic [STATE_W-1:0] IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] WRITE    = 3'd1;
  localparam logic [STATE_W-1:0] RD_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] RD_CAPT  = 3'd3;
  localparam logic [STATE_W-1:0] RESP     = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = IDLE,
    ST_WRITE    = WRITE,
    ST_RD_ISSUE = RD_ISSUE,
    ST_RD_CAPT  = RD_CAPT,
    ST_RESP     = RESP
  } state_t;

endpackage

// File: rtl/reg_bank_ctrl.sv
// Initiator-side controller serialising writebacks and operand reads onto the
// register bank's single-cycle port. Optional macro REDUX_ZERO_REG_EN hardwires register 0 to zero.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int REG_BITS = DEF_REG_BITS,
  parameter int REG_SIZE = DEF_REG_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_valid,
  output logic                rd_ready,
  input  logic [REG_BITS-1:0] rd_addr_a,
  input  logic [REG_BITS-1:0] rd_addr_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BITS-1:0]     rsp_data_a,
  output logic [BITS-1:0]     rsp_data_b,
  input  logic                wb_valid,
  output logic                wb_ready,
  input  logic [REG_BITS-1:0] wb_addr,
  input  logic [BITS-1:0]     wb_data,
  output logic                rb_write_enable,
  output logic [REG_BITS-1:0] rb_address_a,
  output logic [REG_BITS-1:0] rb_address_b,
  output logic [REG_BITS-1:0] rb_write_address,
  output logic [BITS-1:0]     rb_write_data,
  input  logic [BITS-1:0]     rb_data_a,
  input  logic [BITS-1:0]     rb_data_b
);

  // Handshakes: a request transfers on the rising edge where valid && ready.
  // Ready is only offered in IDLE, and writeback wins a tie so a read that
  // waits behind it always observes the freshly written value.

  state_t state;
  logic   ok_a;
  logic   ok_b;
  logic   idle;

  // True when the address maps onto a real, writable/readable register.
  function automatic logic addr_ok(input logic [REG_BITS-1:0] addr);
    logic ok;
    ok = (32'(addr) < 32'(REG_SIZE));
`ifdef REDUX_ZERO_REG_EN
    if (addr == '0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // rst_n gating keeps the readies low while reset is asserted.
  assign idle     = (state == ST_IDLE) && rst_n;
  assign wb_ready = idle && wb_valid;
  assign rd_ready = idle && rd_valid && !wb_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      ok_a             <= 1'b0;
      ok_b             <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_data_a       <= '0;
      rsp_data_b       <= '0;
      rb_write_enable  <= 1'b0;
      rb_address_a     <= '0;
      rb_address_b     <= '0;
      rb_write_address <= '0;
      rb_write_data    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wb_valid) begin
            rb_write_address <= wb_addr;
            rb_write_data    <= wb_data;
            rb_write_enable  <= addr_ok(wb_addr);
            state            <= ST_WRITE;
          end else if (rd_valid) begin
            rb_address_a <= rd_addr_a;
            rb_address_b <= rd_addr_b;
            ok_a         <= addr_ok(rd_addr_a);
            ok_b         <= addr_ok(rd_addr_b);
            state        <= ST_RD_ISSUE;
          end
        end
        ST_WRITE: begin
          rb_write_enable <= 1'b0;
          state           <= ST_IDLE;
        end
        // Bank samples the read addresses at the edge leaving this state.
        ST_RD_ISSUE: begin
          state <= ST_RD_CAPT;
        end
        ST_RD_CAPT: begin
          rsp_data_a <= ok_a ? rb_data_a : '0;
          rsp_data_b <= ok_b ? rb_data_b : '0;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid       <= 1'b0;
          rb_write_enable <= 1'b0;
          state           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
